// File: rtl/mc_pkg.sv
// Shared constants for the multicycle MIPS main controller: state encoding,
// ALU operation codes, opcode/funct values and datapath mux select codes.
// The optional trap state is used only when MC_CTRL_ILLEGAL_TRAP_EN is defined.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECUTE  = 4'd6,
    ST_ALUWB    = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_ADDIEXEC = 4'd9,
    ST_ADDIWB   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_TRAP     = 4'd12
  } state_t;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOR = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b1011;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b1001;
  localparam logic [3:0] ALU_BEQ = 4'b1101;
  localparam logic [3:0] ALU_BNE = 4'b1111;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instruction[5:0])
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;

  // ALU operand-B select
  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// Combinational R-type funct decoder: maps funct to an ALU operation code and
// flags whether the funct is one the controller supports.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] aluctrl,
  output logic       funct_valid
);

  // funct lookup; unsupported codes fall back to ADD and are flagged invalid
  always_comb begin
    aluctrl     = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      F_ADD:   aluctrl = ALU_ADD;
      F_SUB:   aluctrl = ALU_SUB;
      F_AND:   aluctrl = ALU_AND;
      F_OR:    aluctrl = ALU_OR;
      F_XOR:   aluctrl = ALU_XOR;
      F_NOR:   aluctrl = ALU_NOR;
      F_SLT:   aluctrl = ALU_SLT;
      F_SLL:   aluctrl = ALU_SLL;
      F_SRL:   aluctrl = ALU_SRL;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller. Sequences fetch/decode/execute/memory/
// writeback, drives ALU control and datapath enables/selects, and forms pcen
// from the ALU zero flag during branches. Memory accesses (FETCH, MEMREAD)
// last MEM_LAT cycles, timed by a small wait counter.
// Optional feature: define MC_CTRL_ILLEGAL_TRAP_EN to add a TRAP state and an
// "illegal" output; otherwise illegal opcodes/functs behave as NOPs.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] aluctrl,
  output logic [1:0] pcsrc,
  output logic       pcen,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  output logic       illegal,
`endif
  output logic [3:0] state
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_LAT - 1);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_DEST = ST_TRAP;
`else
  localparam state_t ILLEGAL_DEST = ST_FETCH;
`endif

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] waitcnt_reg, waitcnt_next;
  logic             wait_done;

  logic [3:0] dec_aluctrl;
  logic       dec_funct_valid;

  logic memwrite_raw, irwrite_raw, regwrite_raw, pcwrite, branch;

  mc_alu_decoder u_alu_decoder (
    .funct       (funct),
    .aluctrl     (dec_aluctrl),
    .funct_valid (dec_funct_valid)
  );

  assign wait_done = (waitcnt_reg == WAIT_LAST);

  // State register and memory-wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_FETCH;
      waitcnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      waitcnt_reg <= waitcnt_next;
    end
  end

  // Next-state logic; the wait counter only advances while a memory access is pending
  always_comb begin
    state_next   = state_reg;
    waitcnt_next = '0;
    case (state_reg)
      ST_FETCH: begin
        if (wait_done) state_next = ST_DECODE;
        else           waitcnt_next = waitcnt_reg + CNT_W'(1);
      end
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW:   state_next = ST_MEMADR;
          OP_RTYPE:       state_next = ST_EXECUTE;
          OP_BEQ, OP_BNE: state_next = ST_BRANCH;
          OP_ADDI:        state_next = ST_ADDIEXEC;
          OP_J:           state_next = ST_JUMP;
          default:        state_next = ILLEGAL_DEST;
        endcase
      end
      ST_MEMADR:   state_next = (op == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
      ST_MEMREAD: begin
        if (wait_done) state_next = ST_MEMWB;
        else           waitcnt_next = waitcnt_reg + CNT_W'(1);
      end
      ST_EXECUTE:  state_next = dec_funct_valid ? ST_ALUWB : ILLEGAL_DEST;
      ST_ADDIEXEC: state_next = ST_ADDIWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      ST_TRAP:     state_next = ST_TRAP;
`endif
      default:     state_next = ST_FETCH;
    endcase
  end

  // Moore output decode; branch is qualified with zero below
  always_comb begin
    iord         = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = SRCB_RT;
    aluctrl      = ALU_ADD;
    pcsrc        = PC_ALU;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        alusrcb = SRCB_FOUR;
        if (wait_done) begin
          irwrite_raw = 1'b1;
          pcwrite     = 1'b1;
        end
      end
      ST_DECODE:   alusrcb = SRCB_IMMSH;
      ST_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      ST_MEMREAD:  iord = 1'b1;
      ST_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      ST_MEMWRITE: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      ST_EXECUTE: begin
        alusrca = 1'b1;
        aluctrl = dec_aluctrl;
      end
      ST_ALUWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      ST_BRANCH: begin
        alusrca = 1'b1;
        aluctrl = (op == OP_BEQ) ? ALU_BEQ : ALU_BNE;
        pcsrc   = PC_ALUOUT;
        branch  = 1'b1;
      end
      ST_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      ST_ADDIWB:   regwrite_raw = 1'b1;
      ST_JUMP: begin
        pcsrc   = PC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are suppressed while reset is held so no partial write escapes
  assign memwrite = memwrite_raw & ~reset;
  assign irwrite  = irwrite_raw  & ~reset;
  assign regwrite = regwrite_raw & ~reset;
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;
  assign state    = state_reg;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal = (state_reg == ST_TRAP);
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm. Two instances (MEM_LAT=1 and 3)
// are exercised one at a time; each cycle the full output vector is compared
// with a per-instruction expected trace built from the instruction rules.
module tb_mc_control_fsm;
  import mc_pkg::*;

  typedef struct packed {
    logic [3:0] state;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluctrl;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       illegal;
  } ctl_t;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_s [2];
  logic [5:0] op_s    [2];
  logic [5:0] funct_s [2];
  logic       zero;
  ctl_t       obs     [2];
  int         lat_of  [2];

  int errors = 0;
  int checks = 0;

  ctl_t trace[$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, ill;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] aluctrl, st;

    mc_control_fsm #(.MEM_LAT((gi == 0) ? 1 : 3), .CNT_W(4)) u_dut (
      .clk      (clk),
      .reset    (reset_s[gi]),
      .op       (op_s[gi]),
      .funct    (funct_s[gi]),
      .zero     (zero),
      .iord     (iord),
      .memwrite (memwrite),
      .irwrite  (irwrite),
      .regdst   (regdst),
      .memtoreg (memtoreg),
      .regwrite (regwrite),
      .alusrca  (alusrca),
      .alusrcb  (alusrcb),
      .aluctrl  (aluctrl),
      .pcsrc    (pcsrc),
      .pcen     (pcen),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      .illegal  (ill),
`endif
      .state    (st)
    );
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
    assign ill = 1'b0;
`endif
    assign obs[gi] = {st, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                      alusrca, alusrcb, aluctrl, pcsrc, pcen, ill};
  end

  // Default record for a state: everything 0, ALU op ADD
  function automatic ctl_t rec(input state_t s);
    ctl_t c;
    c = '0;
    c.state   = s;
    c.aluctrl = 4'b0010;
    return c;
  endfunction

  // Output pattern expected while reset is held in FETCH
  function automatic ctl_t reset_rec();
    ctl_t c;
    c = rec(ST_FETCH);
    c.alusrcb = 2'b01;
    return c;
  endfunction

  // R-type funct table
  function automatic logic [3:0] funct_code(input logic [5:0] f, output bit valid);
    valid = 1'b1;
    case (f)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100110: return 4'b1011;
      6'b100111: return 4'b0101;
      6'b101010: return 4'b1001;
      6'b000000: return 4'b0011;
      6'b000010: return 4'b0100;
      default: begin
        valid = 1'b0;
        return 4'b0010;
      end
    endcase
  endfunction

  // Build the cycle-by-cycle expected outputs of one instruction, starting at FETCH.
  // traps=1 means the instruction ends by entering TRAP.
  task automatic build_trace(input logic [5:0] op, input logic [5:0] f, input logic z,
                             input int lat, output bit traps);
    ctl_t c;
    bit   fv;
    traps = 1'b0;
    trace.delete();
    for (int i = 0; i < lat; i++) begin
      c = rec(ST_FETCH);
      c.alusrcb = 2'b01;
      if (i == lat - 1) begin
        c.irwrite = 1'b1;
        c.pcen    = 1'b1;
      end
      trace.push_back(c);
    end
    c = rec(ST_DECODE); c.alusrcb = 2'b11; trace.push_back(c);
    case (op)
      6'b100011, 6'b101011: begin
        c = rec(ST_MEMADR); c.alusrca = 1'b1; c.alusrcb = 2'b10; trace.push_back(c);
        if (op == 6'b100011) begin
          for (int i = 0; i < lat; i++) begin
            c = rec(ST_MEMREAD); c.iord = 1'b1; trace.push_back(c);
          end
          c = rec(ST_MEMWB); c.memtoreg = 1'b1; c.regwrite = 1'b1; trace.push_back(c);
        end else begin
          c = rec(ST_MEMWRITE); c.iord = 1'b1; c.memwrite = 1'b1; trace.push_back(c);
        end
      end
      6'b000000: begin
        c = rec(ST_EXECUTE); c.alusrca = 1'b1; c.aluctrl = funct_code(f, fv); trace.push_back(c);
        if (fv) begin
          c = rec(ST_ALUWB); c.regdst = 1'b1; c.regwrite = 1'b1; trace.push_back(c);
        end else begin
          traps = TRAP_EN;
        end
      end
      6'b000100, 6'b000101: begin
        c = rec(ST_BRANCH);
        c.alusrca = 1'b1;
        c.aluctrl = (op == 6'b000100) ? 4'b1101 : 4'b1111;
        c.pcsrc   = 2'b01;
        c.pcen    = z;
        trace.push_back(c);
      end
      6'b001000: begin
        c = rec(ST_ADDIEXEC); c.alusrca = 1'b1; c.alusrcb = 2'b10; trace.push_back(c);
        c = rec(ST_ADDIWB); c.regwrite = 1'b1; trace.push_back(c);
      end
      6'b000010: begin
        c = rec(ST_JUMP); c.pcsrc = 2'b10; c.pcen = 1'b1; trace.push_back(c);
      end
      default: traps = TRAP_EN;
    endcase
  endtask

  task automatic check(input int d, input ctl_t exp, input string tag);
    checks++;
    assert (obs[d] === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs[d], exp);
    end
  endtask

  // Run one instruction on DUT d. Entry/exit: at a falling edge with the DUT in
  // FETCH and its wait counter at 0. abort_at >= 0 asserts reset at that step.
  task automatic run_instr(input int d, input logic [5:0] op, input logic [5:0] f,
                           input logic z, input int abort_at);
    bit   traps;
    ctl_t e;
    op_s[d]    = op;
    funct_s[d] = f;
    zero       = z;
    build_trace(op, f, z, lat_of[d], traps);
    #1;
    for (int i = 0; i < trace.size(); i++) begin
      if (i > 0) @(negedge clk);
      if (i == abort_at) begin
        reset_s[d] = 1'b1;
        #1;
        e = trace[i];
        e.memwrite = 1'b0; e.irwrite = 1'b0; e.regwrite = 1'b0; e.pcen = 1'b0;
        check(d, e, "abort_gate");
        @(negedge clk);
        check(d, reset_rec(), "abort_fetch");
        reset_s[d] = 1'b0;
        $display("instr dut%0d op=%b funct=%b zero=%b aborted at step %0d", d, op, f, z, i);
        return;
      end
      check(d, trace[i], "step");
    end
    if (traps) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        e = rec(ST_TRAP); e.illegal = 1'b1;
        check(d, e, "trap_hold");
      end
      reset_s[d] = 1'b1;
      @(negedge clk);
      check(d, reset_rec(), "trap_reset");
      reset_s[d] = 1'b0;
    end else begin
      @(negedge clk);
    end
    $display("instr dut%0d op=%b funct=%b zero=%b cycles=%0d trap=%0d",
             d, op, f, z, trace.size(), traps);
  endtask

  task automatic run_random(input int d, input int n);
    logic [5:0] ops [8];
    logic [5:0] fns [9];
    logic [5:0] o, f;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b000000, 6'b000010};
    for (int k = 0; k < n; k++) begin
      o = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) o = 6'($urandom);
      f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 8)];
      run_instr(d, o, f, 1'($urandom), -1);
    end
  endtask

  initial begin
    lat_of[0] = 1;
    lat_of[1] = 3;
    for (int d = 0; d < 2; d++) begin
      reset_s[d] = 1'b1;
      op_s[d]    = '0;
      funct_s[d] = '0;
    end
    zero = 1'b0;
    repeat (2) @(negedge clk);
    check(0, reset_rec(), "reset_lat1");
    check(1, reset_rec(), "reset_lat3");

    // MEM_LAT=1 instance
    reset_s[0] = 1'b0;
    run_instr(0, 6'b000000, 6'b100000, 1'b0, -1);   // add
    run_instr(0, 6'b000100, 6'b000000, 1'b1, -1);   // beq taken
    run_random(0, 30);
    reset_s[0] = 1'b1;

    // MEM_LAT=3 instance
    reset_s[1] = 1'b0;
    run_instr(1, 6'b100011, 6'b000000, 1'b0, -1);   // lw
    run_instr(1, 6'b000100, 6'b000000, 1'b1, -1);   // beq, zero=1
    run_instr(1, 6'b000101, 6'b000000, 1'b0, -1);   // bne, zero=0
    run_instr(1, 6'b101011, 6'b000000, 1'b0, -1);   // sw
    run_instr(1, 6'b000010, 6'b000000, 1'b0, -1);   // j
    run_instr(1, 6'b001000, 6'b000000, 1'b0, -1);   // addi
    run_instr(1, 6'b100011, 6'b000000, 1'b0, 6);    // lw, reset during MEMREAD
    run_instr(1, 6'b000000, 6'b100010, 1'b0, -1);   // sub
    run_instr(1, 6'b111111, 6'b000000, 1'b0, -1);   // illegal opcode
    run_instr(1, 6'b000000, 6'b111111, 1'b0, -1);   // illegal funct
    run_instr(1, 6'b000000, 6'b101010, 1'b0, -1);   // slt
    run_random(1, 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
